// File: rtl/approx_ctrl.sv
// Horner-scheme sequencer driving the shared ALU to evaluate a Q4.12 polynomial in t = x - 1.
// Optional APPROX_SAT_EN: saturating intermediate results with sticky ovf_o (wrap and ovf_o = 0 otherwise).
module approx_ctrl #(
   parameter int unsigned DEGREE = 3,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [15:0]       x_i,
   output logic [ADDR_W-1:0] coef_addr_o,
   input  logic [15:0]       coef_i,
   input  logic              coef_sign_i,
   output logic [15:0]       alu_op_a_o,
   output logic [15:0]       alu_op_b_o,
   output logic              alu_sigma_n_o,
   output logic [2:0]        alu_mode_o,
   input  logic [31:0]       alu_res_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [15:0]       result_o,
   output logic              ovf_o
);

`ifdef APPROX_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   localparam logic [2:0] MODE_SUB_ONE  = 3'd1;
   localparam logic [2:0] MODE_ADD_SUB  = 3'd2;
   localparam logic [2:0] MODE_MULTIPLY = 3'd3;
   localparam logic [2:0] MODE_IDLE     = 3'd4;

   localparam bit                HAS_TERMS = (DEGREE > 0);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEGREE);
   localparam logic [ADDR_W-1:0] IDX_INIT  = HAS_TERMS ? ADDR_W'(DEGREE - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_TCALC = 3'd1,
      S_LOAD  = 3'd2,
      S_MUL   = 3'd3,
      S_ADD   = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   state_e state_q, state_d;

   logic [15:0]       x_q, x_d;
   logic [15:0]       t_q, t_d;
   logic [15:0]       acc_q, acc_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [15:0]       result_q, result_d;
   logic              ovf_q, ovf_d;

   // Returns {clamped, value}; clamping only happens when saturation is enabled.
   function automatic logic [16:0] sat16(input logic signed [31:0] v);
      if (SAT_EN && (v > 32'sd32767))
         return {1'b1, 16'h7FFF};
      else if (SAT_EN && (v < -32'sd32768))
         return {1'b1, 16'h8000};
      else
         return {1'b0, v[15:0]};
   endfunction

   logic signed [31:0] res_s;
   logic [16:0]        sat_add;
   logic [16:0]        sat_mul;

   assign res_s   = $signed(alu_res_i);
   assign sat_add = sat16(res_s);
   assign sat_mul = sat16(res_s >>> 12);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_i) state_d = S_TCALC;
         S_TCALC: state_d = S_LOAD;
         S_LOAD:  state_d = HAS_TERMS ? S_MUL : S_DONE;
         S_MUL:   state_d = S_ADD;
         S_ADD:   state_d = (idx_q == '0) ? S_DONE : S_MUL;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ALU command is purely a function of the current state and datapath registers.
   always_comb begin
      alu_mode_o    = MODE_IDLE;
      alu_op_a_o    = 16'h0000;
      alu_op_b_o    = 16'h0000;
      alu_sigma_n_o = 1'b0;
      case (state_q)
         S_TCALC: begin
            alu_mode_o = MODE_SUB_ONE;
            alu_op_a_o = x_q;
         end
         S_LOAD: begin
            alu_mode_o    = MODE_ADD_SUB;
            alu_op_b_o    = coef_i;
            alu_sigma_n_o = coef_sign_i;
         end
         S_MUL: begin
            alu_mode_o = MODE_MULTIPLY;
            alu_op_a_o = acc_q;
            alu_op_b_o = t_q;
         end
         S_ADD: begin
            alu_mode_o    = MODE_ADD_SUB;
            alu_op_a_o    = acc_q;
            alu_op_b_o    = coef_i;
            alu_sigma_n_o = coef_sign_i;
         end
         default: ;
      endcase
   end

   always_comb begin
      x_d      = x_q;
      t_d      = t_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               x_d    = x_i;
               addr_d = LAST_ADDR;
               busy_d = 1'b1;
               ovf_d  = 1'b0;
            end
         end
         S_TCALC: t_d = alu_res_i[15:0];
         S_LOAD: begin
            acc_d  = sat_add[15:0];
            ovf_d  = ovf_q | sat_add[16];
            addr_d = addr_q - ADDR_W'(1);
            idx_d  = IDX_INIT;
         end
         S_MUL: begin
            acc_d = sat_mul[15:0];
            ovf_d = ovf_q | sat_mul[16];
         end
         S_ADD: begin
            acc_d = sat_add[15:0];
            ovf_d = ovf_q | sat_add[16];
            if (idx_q != '0) begin
               idx_d  = idx_q - ADDR_W'(1);
               addr_d = addr_q - ADDR_W'(1);
            end
         end
         S_DONE: busy_d = 1'b0;
         default: ;
      endcase
      // Result is captured on the edge that enters DONE (from LOAD or the final ADD).
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
         result_d = sat_add[15:0];
         done_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q      <= '0;
         t_q      <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         addr_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         x_q      <= x_d;
         t_q      <= t_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         addr_q   <= addr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
      end
   end

   assign coef_addr_o = addr_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign result_o    = result_q;
   assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_approx_ctrl.sv
// Randomized self-checking bench for approx_ctrl with a behavioural ALU, coefficient LUT and Horner model.
module tb_approx_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   // Shared coefficient LUT contents
   logic [15:0] coef_mag [16];
   bit          coef_neg [16];

   // DEGREE = 3 instance
   logic        start_i;
   logic [15:0] x_i;
   logic [3:0]  coef_addr;
   logic [15:0] coef;
   logic        coef_sign;
   logic [15:0] op_a, op_b;
   logic        sigma_n;
   logic [2:0]  alu_mode;
   logic [31:0] alu_res;
   logic        busy, done, ovf;
   logic [15:0] result;

   // DEGREE = 0 instance
   logic        start0;
   logic [15:0] x0;
   logic [3:0]  coef_addr0;
   logic [15:0] coef0;
   logic        coef_sign0;
   logic [15:0] op_a0, op_b0;
   logic        sigma_n0;
   logic [2:0]  alu_mode0;
   logic [31:0] alu_res0;
   logic        busy0, done0, ovf0;
   logic [15:0] result0;

   int n_checks = 0;
   int n_err    = 0;
   int n_done   = 0;
   int n_starts = 0;

   function automatic logic [31:0] alu_f(input logic [2:0] m, input logic [15:0] a,
                                         input logic [15:0] b, input logic s);
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (m)
         3'd0:    return 32'(sa + 4096);
         3'd1:    return 32'(sa - 4096);
         3'd2:    return s ? 32'(sa - sb) : 32'(sa + sb);
         3'd3:    return 32'(sa * sb);
         default: return 32'd0;
      endcase
   endfunction

   assign coef       = coef_mag[coef_addr];
   assign coef_sign  = coef_neg[coef_addr];
   assign alu_res    = alu_f(alu_mode, op_a, op_b, sigma_n);
   assign coef0      = coef_mag[coef_addr0];
   assign coef_sign0 = coef_neg[coef_addr0];
   assign alu_res0   = alu_f(alu_mode0, op_a0, op_b0, sigma_n0);

   approx_ctrl #(.DEGREE(3), .ADDR_W(4)) u_dut (
      .clk(clk), .rst(rst), .start_i(start_i), .x_i(x_i),
      .coef_addr_o(coef_addr), .coef_i(coef), .coef_sign_i(coef_sign),
      .alu_op_a_o(op_a), .alu_op_b_o(op_b), .alu_sigma_n_o(sigma_n),
      .alu_mode_o(alu_mode), .alu_res_i(alu_res),
      .busy_o(busy), .done_o(done), .result_o(result), .ovf_o(ovf)
   );

   approx_ctrl #(.DEGREE(0), .ADDR_W(4)) u_dut0 (
      .clk(clk), .rst(rst), .start_i(start0), .x_i(x0),
      .coef_addr_o(coef_addr0), .coef_i(coef0), .coef_sign_i(coef_sign0),
      .alu_op_a_o(op_a0), .alu_op_b_o(op_b0), .alu_sigma_n_o(sigma_n0),
      .alu_mode_o(alu_mode0), .alu_res_i(alu_res0),
      .busy_o(busy0), .done_o(done0), .result_o(result0), .ovf_o(ovf0)
   );

   always @(posedge clk) if (done) n_done <= n_done + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int wrap16(input int v);
      logic signed [15:0] w;
      w = v[15:0];
      return int'(w);
   endfunction

   function automatic int sat_m(input int v, inout bit o);
`ifdef APPROX_SAT_EN
      if (v > 32767) begin o = 1'b1; return 32767; end
      if (v < -32768) begin o = 1'b1; return -32768; end
      return v;
`else
      return wrap16(v);
`endif
   endfunction

   function automatic int floor_q12(input int p);
      int q;
      q = p / 4096;
      if ((p % 4096) != 0 && p < 0) q = q - 1;
      return q;
   endfunction

   function automatic int cval(input int i);
      int m;
      m = int'(coef_mag[i]);
      return coef_neg[i] ? -m : m;
   endfunction

   task automatic ref_eval(input logic [15:0] x, input int deg,
                           output logic [15:0] res, output logic o);
      int t, acc;
      bit ov;
      ov  = 1'b0;
      t   = wrap16(int'($signed(x)) - 4096);
      acc = sat_m(cval(deg), ov);
      for (int i = deg - 1; i >= 0; i--) begin
         acc = sat_m(floor_q12(acc * t), ov);
         acc = sat_m(acc + cval(i), ov);
      end
      res = 16'(acc);
      o   = ov;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic set_coefs(input logic [15:0] m3, input bit n3, input logic [15:0] m2, input bit n2,
                            input logic [15:0] m1, input bit n1, input logic [15:0] m0, input bit n0);
      coef_mag[3] = m3; coef_neg[3] = n3;
      coef_mag[2] = m2; coef_neg[2] = n2;
      coef_mag[1] = m1; coef_neg[1] = n1;
      coef_mag[0] = m0; coef_neg[0] = n0;
   endtask

   // Runs one evaluation; records the ALU mode per busy cycle and the LUT address of each add.
   task automatic run_eval(input logic [15:0] x, input bit hold, output int lat,
                           output logic [15:0] res, output logic o,
                           output logic [23:0] mseq, output logic [15:0] aseq);
      lat  = 0;
      mseq = '0;
      aseq = '0;
      @(negedge clk);
      x_i     = x;
      start_i = 1'b1;
      @(posedge clk); #1;
      if (!hold) start_i = 1'b0;
      x_i = 16'($urandom);
      n_starts++;
      for (int k = 1; k <= 40; k++) begin
         mseq = {mseq[20:0], alu_mode};
         if (alu_mode == 3'd2) aseq = {aseq[11:0], coef_addr};
         @(posedge clk); #1;
         if (done) begin
            lat = k;
            break;
         end
      end
      res = result;
      o   = ovf;
      @(posedge clk); #1;
      start_i = 1'b0;
      check("busy_after_done", 32'(busy), 32'd0);
      check("done_one_cycle", 32'(done), 32'd0);
   endtask

   initial begin
      int          lat;
      logic [15:0] res, exp_res;
      logic        o, exp_o;
      logic [23:0] mseq;
      logic [15:0] aseq;
      logic [23:0] exp_m;

      rst = 1'b1; start_i = 1'b0; x_i = '0; start0 = 1'b0; x0 = '0;
      for (int i = 0; i < 16; i++) begin coef_mag[i] = '0; coef_neg[i] = 1'b0; end
      repeat (2) @(posedge clk);
      #1;
      check("rst_mode", 32'(alu_mode), 32'd4);
      check("rst_ops", {op_a, op_b}, 32'd0);
      check("rst_sigma", 32'(sigma_n), 32'd0);
      check("rst_addr", 32'(coef_addr), 32'd0);
      check("rst_flags", {29'd0, busy, done, ovf}, 32'd0);
      check("rst_result", 32'(result), 32'd0);
      @(negedge clk); rst = 1'b0;

      // x = 1.0 gives t = 0, result is c0 = 0
      set_coefs(16'h0555, 1'b0, 16'h0800, 1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0);
      run_eval(16'h1000, 1'b0, lat, res, o, mseq, aseq);
      check("x1_latency", 32'(lat), 32'd8);
      check("x1_result", 32'(res), 32'h0000);
      check("x1_ovf", 32'(o), 32'd0);

      // x = 1.5 worked example
      run_eval(16'h1800, 1'b0, lat, res, o, mseq, aseq);
      exp_m = {3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2};
      check("x15_modes", 32'(mseq), 32'(exp_m));
      check("x15_addrs", 32'(aseq), 32'h3210);
      check("x15_result", 32'(res), 32'h06AA);

      // Large coefficients: clamp or wrap depending on build
      set_coefs(16'h7000, 1'b0, 16'h7000, 1'b0, 16'h7000, 1'b0, 16'h7000, 1'b0);
      run_eval(16'h7000, 1'b0, lat, res, o, mseq, aseq);
      ref_eval(16'h7000, 3, exp_res, exp_o);
      check("big_result", 32'(res), 32'(exp_res));
      check("big_ovf", 32'(o), 32'(exp_o));

      // start held high through the whole evaluation and DONE
      set_coefs(16'h0555, 1'b0, 16'h0800, 1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0);
      run_eval(16'h1800, 1'b1, lat, res, o, mseq, aseq);
      check("hold_latency", 32'(lat), 32'd8);
      check("hold_result", 32'(res), 32'h06AA);
      repeat (12) @(posedge clk);
      #1;
      check("hold_no_restart", 32'(busy), 32'd0);
      check("hold_done_count", 32'(n_done), 32'(n_starts));

      // Reset during the second MUL aborts the evaluation
      @(negedge clk);
      x_i = 16'h1800; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("abort_in_mul", 32'(alu_mode), 32'd3);
      rst = 1'b1;
      #1;
      check("abort_mode", 32'(alu_mode), 32'd4);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_result", 32'(result), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      @(negedge clk); rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("abort_no_done", 32'(n_done), 32'(n_starts));
      run_eval(16'h1800, 1'b0, lat, res, o, mseq, aseq);
      check("after_abort_result", 32'(res), 32'h06AA);

      // Randomized coefficients and arguments
      for (int it = 0; it < 16; it++) begin
         for (int i = 0; i < 4; i++) begin
            coef_mag[i] = (it < 8) ? 16'($urandom_range(0, 16'h1FFF)) : 16'($urandom_range(0, 16'h7FFF));
            coef_neg[i] = 1'($urandom);
         end
         x_i = 16'($urandom);
         exp_res = x_i;
         run_eval(exp_res, 1'($urandom), lat, res, o, mseq, aseq);
         check("rnd_latency", 32'(lat), 32'd8);
         ref_eval(exp_res, 3, exp_res, exp_o);
         check("rnd_result", 32'(res), 32'(exp_res));
         check("rnd_ovf", 32'(o), 32'(exp_o));
      end
      check("total_done_count", 32'(n_done), 32'(n_starts));

      // DEGREE = 0 instance: result is c0 after two edges
      coef_mag[0] = 16'h0400; coef_neg[0] = 1'b1;
      @(negedge clk);
      x0 = 16'h2345; start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (done0) begin lat = k; break; end
      end
      check("deg0_latency", 32'(lat), 32'd2);
      check("deg0_result", 32'(result0), 32'h0000FC00);
      check("deg0_ovf", 32'(ovf0), 32'd0);
      ref_eval(16'h2345, 0, exp_res, exp_o);
      check("deg0_model", 32'(result0), 32'(exp_res));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/approx_ctrl.md
Name: approx_ctrl

Overview:
- Sequencer that drives the shared combinational ALU (mode/operand/sigma_n interface) to evaluate a Q4.12 polynomial approximation in t = x - 1 with Horner's scheme.
- Issues one ALU operation per cycle and registers the 32-bit ALU result.
- Fetches signed-magnitude coefficients from an asynchronous coefficient LUT.
- Reports a 16-bit Q4.12 result with a start/done handshake. It sits between the approximation top level and the ALU.

Parameters:
- DEGREE, 3, polynomial degree; coefficients c_DEGREE..c_0 at LUT addresses DEGREE..0.
- ADDR_W, 4, coefficient address width; must satisfy 2^ADDR_W > DEGREE.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- start_i  in  1  start request, sampled in IDLE only
- x_i  in  16  signed Q4.12 argument, sampled with start_i
- coef_addr_o  out  ADDR_W  registered coefficient LUT address
- coef_i  in  16  coefficient magnitude Q4.12, combinational read of coef_addr_o
- coef_sign_i  in  1  coefficient sign, 1 = negative
- alu_op_a_o  out  16  signed ALU operand A
- alu_op_b_o  out  16  signed ALU operand B
- alu_sigma_n_o  out  1  ALU add/sub select, 1 = subtract
- alu_mode_o  out  3  0 = ADD_ONE, 1 = SUB_ONE, 2 = ADD_SUB, 3 = MULTIPLY, 4 = ALU_IDLE
- alu_res_i  in  32  signed ALU result, combinational in the same cycle
- busy_o  out  1  high from the start-accept edge until the DONE state is left
- done_o  out  1  one-cycle pulse, result_o valid
- result_o  out  16  signed Q4.12 result, held until the next done_o
- ovf_o  out  1  sticky overflow flag for the current evaluation (see Optional Feature)

Behaviour:
- Reset (async, any state): state = IDLE; all ALU outputs at idle values (mode = 4, op_a = op_b = 0, sigma_n = 0); coef_addr_o = 0; busy_o = 0; done_o = 0; result_o = 0; ovf_o = 0; internal t, acc, idx = 0.
- ALU outputs are combinational from state plus registers.
- ALU outputs equal idle values in IDLE and DONE.
- States and the ALU command driven in each state:
  - IDLE: if start_i = 1, capture x_i, set coef_addr_o = DEGREE, busy_o = 1, clear ovf_o, go to T_CALC. Otherwise remain.
  - T_CALC: mode = 1, op_a = x. Capture t = alu_res_i[15:0]; Q4.12 wrap is acceptable by construction. Go to LOAD.
  - LOAD: mode = 2, op_a = 0, op_b = coef_i, sigma_n = coef_sign_i. acc = sat16(alu_res_i); coef_addr_o -= 1; idx = DEGREE - 1. Go to MUL if DEGREE > 0, else DONE.
  - MUL: mode = 3, op_a = acc, op_b = t. acc = sat16(alu_res_i >>> 12), arithmetic shift. Go to ADD.
  - ADD: mode = 2, op_a = acc, op_b = coef_i, sigma_n = coef_sign_i. acc = sat16(alu_res_i). If idx == 0, go to DONE; else idx -= 1, coef_addr_o -= 1, go to MUL.
  - DONE: done_o = 1, result_o = acc (registered on entry). Next edge: busy_o = 0, go to IDLE.
- Latency:
  - Start sampled at edge E0; done_o is high in the cycle after edge E0 + 2 + 2*DEGREE. DEGREE = 3 gives 8 edges.
  - Earliest re-start is the edge after DONE, one idle cycle.
- start_i outside IDLE, including during DONE, is ignored; x_i changes while busy have no effect.
- sat16: clamp to [-32768, 32767]. ovf_o is set if any clamp occurs; it is cleared at the next accepted start.
- coef_i and coef_sign_i are sampled only in LOAD and ADD.
- Reset mid-evaluation aborts with no done_o; result_o returns to 0.

Optional Feature:
- Macro APPROX_SAT_EN.
- Defined: sat16 clamps as above and ovf_o is sticky as described.
- Undefined: sat16 is plain truncation to the low 16 bits (two's-complement wrap) and ovf_o is tied to 0.

Test Plan:
- Coefficients c3 = +0x0555, c2 = -0x0800, c1 = +0x1000, c0 = +0x0000. Start with x_i = 0x1000 (1.0) -> done_o after 8 edges, result_o = 0x0000, ovf_o = 0.
- Same coefficients, x_i = 0x1800 (1.5) -> ALU mode sequence 1, 2, 3, 2, 3, 2, 3, 2; coef_addr_o sequence 3, 2, 1, 0; intermediate acc values 0x0555, 0x02AA, 0xFAAA, 0xFD55, 0x0D55, 0x06AA, 0x06AA; result_o = 0x06AA.
- All coefficients +0x7000, x_i = 0x7000 -> with APPROX_SAT_EN: first MUL clamps, result_o = 0x7FFF, ovf_o = 1. Without the macro: wrapped value, ovf_o = 0.
- Pulse start_i every cycle during a busy evaluation -> exactly one done_o per accepted start; second start accepted only from IDLE.
- Assert rst during the second MUL -> same-cycle alu_mode_o = 4, busy_o = 0, result_o = 0, no done_o. A fresh start then yields a correct result.
- DEGREE = 0 build, c0 = -0x0400 -> done_o after 2 edges, result_o = 0xFC00.
